clock_div: RTL and testbench
============================

CLOCK_DIV -- requirements
Module: clock_div

Interface
REQ-001 Parameter: WIDTH, default 26, bit width of the divisor input and of the internal counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: div  input  WIDTH  half-period length in clk cycles; unsigned.
REQ-005 Port: clock_out  output  1  divided clock; registered output, no combinational path from any input.
REQ-006 Port order SHALL be clk, rst, div, clock_out, to support positional instantiation; the optional port in REQ-021 SHALL be appended last.

Function
REQ-007 Internal state SHALL be: counter cnt (WIDTH bits), latched divisor div_q (WIDTH bits), output register out.
REQ-008 Each rising clk edge with div_q == 0: div_q <= div, cnt <= 0, out <= 0.
REQ-009 Each rising clk edge with div_q != 0 and cnt == div_q-1: cnt <= 0, out <= ~out, div_q <= div.
REQ-010 Each rising clk edge with div_q != 0 and cnt != div_q-1: cnt <= cnt+1; out and div_q hold.
REQ-011 With a constant div = N >= 1, clock_out SHALL have a period of 2N clk cycles and a 50 % duty cycle (N high, N low).
REQ-012 div = 1 SHALL give clock_out = clk/2, toggling on every edge after the load edge.
REQ-013 div = 0 SHALL hold clock_out low and cnt at 0 for as long as div stays 0.
REQ-014 A div change mid-half-period SHALL take effect only at the next toggle edge; the current half-period completes at the old length.
REQ-015 A change of div to 0 SHALL force clock_out low on the edge after the boundary at which 0 was latched.
REQ-016 The counter SHALL never wrap: cnt <= div_q-1 always holds. div = 2^WIDTH-1 is legal.
REQ-017 First rising edge of clock_out after reset release SHALL occur on clk edge N+1 (one load edge plus N counting edges).

Reset
REQ-018 While rst = 1, asynchronously: cnt = 0, div_q = 0, out = 0, so clock_out = 0 immediately, without waiting for a clk edge.
REQ-019 Reset asserted mid-operation SHALL abort the current period; operation restarts from REQ-017 after release.
REQ-020 The first clk edge after release SHALL be a load edge (REQ-008).

Configuration
REQ-021 Macro CLOCK_DIV_TICK_EN:
- Defined: adds output port tick, 1 bit, appended after clock_out; registered.
- tick SHALL pulse high for exactly one clk cycle, asserted on the same edge at which clock_out goes 0->1.
- tick is 0 during and after reset.
- Not defined: no tick port and no associated logic.

Verification
REQ-022 Reset and startup: clk period 2 ns, div = 30; pulse rst for one cycle -> clock_out = 0 during reset; first rise on edge 31 after release; then high 30 / low 30 cycles repeatedly for at least 500 cycles.
REQ-023 Minimum division: div = 1 -> clock_out toggles every edge after the load edge (clk/2).
REQ-024 Zero divisor and mid-period change:
- div = 0 for 20 cycles -> clock_out constantly 0.
- Running at div = 30, set div = 5 at cnt = 10 -> current half-period still 30 cycles; following half-periods 5 cycles each.
REQ-025 Mid-operation reset: assert rst asynchronously, mid-cycle, while clock_out = 1 -> clock_out drops to 0 before the next clk edge; after release, restart timing matches REQ-022.
REQ-026 With CLOCK_DIV_TICK_EN defined and div = 4 -> tick is a single-cycle pulse every 8 cycles, aligned with each clock_out rising edge. Without the macro -> the design elaborates with exactly four ports.

Source files
------------

// File: rtl/clock_div.sv
// rtl/clock_div.sv - programmable 50% duty clock divider, half-period = div clk cycles
// Optional macro CLOCK_DIV_TICK_EN adds a registered one-cycle tick on each clock_out rise.
module clock_div #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div,
  output logic             clock_out
`ifdef CLOCK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             out_q, out_d;
  logic             idle;
  logic             last;

  assign idle = (div_q == '0);
  assign last = (cnt_q == div_q - WIDTH'(1));

  // The divisor is only sampled at a half-period boundary (or while idle), so a
  // change never truncates or stretches the half-period in progress.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    out_d = out_q;
    if (idle) begin
      div_d = div;
      cnt_d = '0;
      out_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      out_d = ~out_q;
      div_d = div;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      out_q <= out_d;
    end
  end

  assign clock_out = out_q;

`ifdef CLOCK_DIV_TICK_EN
  logic tick_q, tick_d;

  assign tick_d = !idle && last && !out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_div.sv
// tb/tb_clock_div.sv - directed self-checking bench for clock_div
`timescale 1ns/100ps
module tb_clock_div;
  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] div = W'(30);
  logic         clock_out;
`ifdef CLOCK_DIV_TICK_EN
  logic         tick;
`endif

  int n_checks = 0;
  int n_errors = 0;

  clock_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .div       (div),
    .clock_out (clock_out)
`ifdef CLOCK_DIV_TICK_EN
    ,
    .tick      (tick)
`endif
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #0.5;
  endtask

  task automatic do_reset(input logic [W-1:0] d);
    @(negedge clk);
    rst = 1'b1;
    div = d;
    #0.3;
    check("rst_async", clock_out, 1'b0);
    @(posedge clk);
    #0.5;
    check("rst_hold", clock_out, 1'b0);
`ifdef CLOCK_DIV_TICK_EN
    check("rst_tick", tick, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Edge k after release: edge 1 loads, toggles land on edges N+1, 2N+1, ...
  task automatic run_const(input string tag, input int n, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      step();
      check($sformatf("%s k=%0d", tag, k), clock_out, 1'(((k - 1) / n) % 2));
    end
  endtask

  initial begin
    #0.5;
    check("reset_init", clock_out, 1'b0);
`ifdef CLOCK_DIV_TICK_EN
    check("reset_init_tick", tick, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_const("run30", 30, 520);

    // k=520 lies in a high half-period; reset mid-cycle must drop the output at once
    check("pre_rst_high", clock_out, 1'b1);
    #0.2;
    rst = 1'b1;
    #0.2;
    check("async_drop", clock_out, 1'b0);
    @(posedge clk);
    #0.5;
    check("async_hold", clock_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_const("restart30", 30, 70);

    do_reset(W'(0));
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("div0 k=%0d", k), clock_out, 1'b0);
    end
    div = W'(1);
    run_const("div1", 1, 20);

    // div 30 -> 5 at cnt=10 (after edge 11), then -> 0 after edge 80
    do_reset(W'(30));
    for (int k = 1; k <= 100; k++) begin
      logic e;
      step();
      if (k <= 30) e = 1'b0;
      else if (k <= 81) e = 1'(((k - 31) / 5) % 2 == 0);
      else e = 1'b0;
      check($sformatf("change k=%0d", k), clock_out, e);
      if (k == 11) div = W'(5);
      if (k == 80) div = W'(0);
    end

    do_reset(W'(4));
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("div4 k=%0d", k), clock_out, 1'(((k - 1) / 4) % 2));
`ifdef CLOCK_DIV_TICK_EN
      check($sformatf("tick k=%0d", k), tick, 1'((k - 1) % 8 == 4));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
